// File: rtl/pulse_evt_pkg.sv
// Shared constants, slot states and helpers
// for the pulse event arbiter.
package pulse_evt_pkg;

  localparam int N_CH_DEF = 8;
  localparam int TS_W_DEF = 32;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/pulse_event_arbiter_rr_pick.sv
// Combinational round-robin picker:
// first set request at or after ptr, circularly.
module rr_pick
  import pulse_evt_pkg::*;
#(
  parameter  int N_CH = N_CH_DEF,
  localparam int ID_W = clog2(N_CH)
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic            gnt_valid_o,
  output logic [ID_W-1:0] gnt_idx_o
);

  logic [2*N_CH-1:0] dbl;
  logic [N_CH-1:0]   rot;
  logic [ID_W:0]     sum;

  always_comb begin
    dbl = {req_i, req_i} >> ptr_i;
    rot = dbl[N_CH-1:0];
    gnt_valid_o = |req_i;
    sum = '0;
    for (int k = N_CH - 1; k >= 0; k--)
      if (rot[k]) sum = (ID_W+1)'(k);
    sum = sum + {1'b0, ptr_i};
    // rotated offset back to an absolute channel index
    if (sum >= (ID_W+1)'(N_CH))
      sum = sum - (ID_W+1)'(N_CH);
    gnt_idx_o = sum[ID_W-1:0];
  end

endmodule

// File: rtl/pulse_event_arbiter.sv
// Timestamps channel pulses, latches them as pending
// requests and serializes them onto one event stream.
module pulse_event_arbiter
  import pulse_evt_pkg::*;
#(
  parameter  int N_CH = N_CH_DEF,
  parameter  int TS_W = TS_W_DEF,
  localparam int ID_W = clog2(N_CH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable_i,
  input  logic [N_CH-1:0] pulse_i,
  output logic            evt_valid_o,
  input  logic            evt_ready_i,
  output logic [ID_W-1:0] evt_ch_o,
  output logic [TS_W-1:0] evt_ts_o,
  output logic [N_CH-1:0] pending_o,
  output logic [N_CH-1:0] overflow_o,
  input  logic [N_CH-1:0] overflow_clr_i
);

  slot_e           state_q, state_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic [N_CH-1:0] pend_q, pend_d;
  logic [N_CH-1:0] ovf_q, ovf_d;
  logic [TS_W-1:0] lat_q [N_CH];
  logic [TS_W-1:0] lat_d [N_CH];
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] ch_q, ch_d;
  logic [TS_W-1:0] ets_q, ets_d;

  logic            gnt_vld;
  logic [ID_W-1:0] gnt_idx;
  logic            free;
  logic            grant;
  logic [N_CH-1:0] cap;
  logic [N_CH-1:0] gsel;
  logic [N_CH-1:0] ovf_set;

  rr_pick #(.N_CH(N_CH)) u_pick (
    .req_i      (pend_q),
    .ptr_i      (ptr_q),
    .gnt_valid_o(gnt_vld),
    .gnt_idx_o  (gnt_idx)
  );

  always_comb begin
    free    = (state_q == S_EMPTY) || evt_ready_i;
    grant   = free && gnt_vld;
    state_d = state_q;
    ch_d    = ch_q;
    ets_d   = ets_q;
    ptr_d   = ptr_q;
    unique case (1'b1)
      grant: begin
        state_d = S_FULL;
        ch_d    = gnt_idx;
        ets_d   = lat_q[gnt_idx];
        ptr_d   = (gnt_idx == ID_W'(N_CH - 1))
                  ? '0 : gnt_idx + ID_W'(1);
      end
      (free && !gnt_vld): state_d = S_EMPTY;
      default: ;
    endcase
  end

  always_comb begin
    cap  = enable_i ? pulse_i : '0;
    gsel = '0;
    if (grant) gsel[gnt_idx] = 1'b1;
    pend_d  = pend_q & ~gsel;
    lat_d   = lat_q;
    ovf_set = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (cap[i]) begin
        // a pulse on the channel being granted re-arms it
        if (!pend_q[i] || gsel[i]) begin
          pend_d[i] = 1'b1;
          lat_d[i]  = ts_q;
        end else begin
          ovf_set[i] = 1'b1;
        end
      end
    end
    ovf_d = (ovf_q & ~overflow_clr_i) | ovf_set;
    ts_d  = enable_i ? ts_q + TS_W'(1) : ts_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_EMPTY;
      ts_q    <= '0;
      pend_q  <= '0;
      ovf_q   <= '0;
      ptr_q   <= '0;
      ch_q    <= '0;
      ets_q   <= '0;
      for (int i = 0; i < N_CH; i++)
        lat_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      ptr_q   <= ptr_d;
      ch_q    <= ch_d;
      ets_q   <= ets_d;
      for (int i = 0; i < N_CH; i++)
        lat_q[i] <= lat_d[i];
    end
  end

  assign evt_valid_o = (state_q == S_FULL);
  assign evt_ch_o    = ch_q;
  assign evt_ts_o    = ets_q;
  assign pending_o   = pend_q;
  assign overflow_o  = ovf_q;

endmodule
